// File: rtl/comet_pkg.sv
// Comet shared definitions: sprite table geometry, sprite DMA register map and FSM states.
package comet_pkg;

    localparam int DEF_SPR_COUNT      = 16;
    localparam int DEF_SPR_ITEM_BYTES = 4;

    localparam logic [1:0] REG_SRC_LO = 2'd0;
    localparam logic [1:0] REG_SRC_HI = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IMM     = 1;
    localparam int CTRL_IRQ_ACK = 7;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ARMED   = 1;
    localparam int STAT_OVERRUN = 2;
    localparam int STAT_DONE    = 3;
    localparam int STAT_IRQ     = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_REQ  = 3'd2,
        ST_RD   = 3'd3,
        ST_LAT  = 3'd4,
        ST_WR   = 3'd5,
        ST_DONE = 3'd6
    } dma_state_t;

endpackage

// File: rtl/sprite_dma_regs.sv
// sprite_dma_regs: CPU register decode, read mux and sticky status bits for sprite_dma.
// SPRITE_DMA_IRQ_EN adds the completion interrupt and its CTRL bit7 acknowledge.
module sprite_dma_regs
    import comet_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_wr,
    input  logic [1:0]  reg_addr,
    input  logic [7:0]  reg_din,
    output logic [7:0]  reg_dout,
    input  logic        busy,
    input  logic        armed,
    input  logic        done_set,
    input  logic        overrun_set,
    output logic [15:0] src_reg,
    output logic        start_go,
    output logic        start_imm,
    output logic        irq
);

    logic [7:0] src_lo;
    logic [7:0] src_hi;
    logic       done_q;
    logic       overrun_q;
    logic       ctrl_wr;

    assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
    // START is only honoured from IDLE; while busy it leaves status untouched
    assign start_go  = ctrl_wr && reg_din[CTRL_START] && !busy;
    assign start_imm = reg_din[CTRL_IMM];
    assign src_reg   = {src_hi, src_lo};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_lo    <= 8'h00;
            src_hi    <= 8'h00;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (reg_wr && (reg_addr == REG_SRC_LO)) src_lo <= reg_din;
            if (reg_wr && (reg_addr == REG_SRC_HI)) src_hi <= reg_din;
            if (done_set)         done_q <= 1'b1;
            else if (start_go)    done_q <= 1'b0;
            if (overrun_set)      overrun_q <= 1'b1;
            else if (start_go)    overrun_q <= 1'b0;
        end
    end

`ifdef SPRITE_DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else if (done_set) begin
            irq_q <= 1'b1;
        end else if (ctrl_wr && reg_din[CTRL_IRQ_ACK]) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        reg_dout = 8'h00;
        case (reg_addr)
            REG_SRC_LO: reg_dout = src_lo;
            REG_SRC_HI: reg_dout = src_hi;
            REG_CTRL: begin
                reg_dout[STAT_BUSY]    = busy;
                reg_dout[STAT_ARMED]   = armed;
                reg_dout[STAT_OVERRUN] = overrun_q;
                reg_dout[STAT_DONE]    = done_q;
                reg_dout[STAT_IRQ]     = irq;
            end
            default: reg_dout = 8'h00;
        endcase
    end

endmodule

// File: rtl/sprite_dma.sv
// sprite_dma: copies the sprite attribute table from CPU work RAM into sprite RAM.
// Completion interrupt is built only when SPRITE_DMA_IRQ_EN is defined.
//
// state | meaning
// IDLE  | waiting for START
// ARM   | started, waiting for vblank (or IMMEDIATE)
// REQ   | bus_req high, waiting for bus_ack
// RD    | work RAM read of byte idx
// LAT   | read data captured into the write register
// WR    | sprite RAM write of byte idx
// DONE  | bus released, done/irq set for one cycle
module sprite_dma
    import comet_pkg::*;
#(
    parameter int SPR_COUNT      = DEF_SPR_COUNT,
    parameter int SPR_ITEM_BYTES = DEF_SPR_ITEM_BYTES,
    parameter int SRC_AW         = 16,
    parameter int DST_AW         = 7
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              reg_wr,
    input  logic [1:0]        reg_addr,
    input  logic [7:0]        reg_din,
    output logic [7:0]        reg_dout,
    input  logic              vblank,
    output logic              bus_req,
    input  logic              bus_ack,
    output logic [SRC_AW-1:0] src_addr,
    output logic              src_rd,
    input  logic [7:0]        src_data,
    output logic [DST_AW-1:0] spriteram_addr,
    output logic [7:0]        spriteram_data_in,
    output logic              spriteram_wr,
    output logic              busy,
    output logic              irq
);

    localparam int LAST_IDX = SPR_COUNT * SPR_ITEM_BYTES - 1;

    dma_state_t        state;
    dma_state_t        state_nxt;
    logic [DST_AW-1:0] idx;
    logic [SRC_AW-1:0] base_q;
    logic              imm_q;
    logic              vblank_q;
    logic [15:0]       src_reg;
    logic              start_go;
    logic              start_imm;
    logic              in_xfer;
    logic              last_byte;
    logic              overrun_set;

    sprite_dma_regs u_regs (
        .clk         (clk),
        .reset_n     (reset_n),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_din     (reg_din),
        .reg_dout    (reg_dout),
        .busy        (busy),
        .armed       (state == ST_ARM),
        .done_set    (state == ST_DONE),
        .overrun_set (overrun_set),
        .src_reg     (src_reg),
        .start_go    (start_go),
        .start_imm   (start_imm),
        .irq         (irq)
    );

    assign in_xfer     = (state == ST_REQ) || (state == ST_RD) || (state == ST_LAT) || (state == ST_WR);
    assign last_byte   = (idx == DST_AW'(LAST_IDX));
    assign overrun_set = in_xfer && vblank_q && !vblank && !imm_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_go)          state_nxt = ST_ARM;
            ST_ARM:  if (vblank || imm_q)   state_nxt = ST_REQ;
            ST_REQ:  if (bus_ack)           state_nxt = ST_RD;
            ST_RD:   if (bus_ack)           state_nxt = ST_LAT;
            ST_LAT:  if (bus_ack)           state_nxt = ST_WR;
            ST_WR:   if (bus_ack)           state_nxt = last_byte ? ST_DONE : ST_RD;
            ST_DONE:                        state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= ST_IDLE;
            idx               <= '0;
            base_q            <= '0;
            imm_q             <= 1'b0;
            vblank_q          <= 1'b0;
            spriteram_data_in <= 8'h00;
        end else begin
            state    <= state_nxt;
            vblank_q <= vblank;
            if (start_go) begin
                idx    <= '0;
                base_q <= SRC_AW'(src_reg);
                imm_q  <= start_imm;
            end else if ((state == ST_WR) && bus_ack && !last_byte) begin
                idx <= idx + 1'b1;
            end else if (state == ST_DONE) begin
                idx <= '0;
            end
            // work RAM holds its last read, so a stalled LAT still captures the right byte
            if ((state == ST_LAT) && bus_ack) spriteram_data_in <= src_data;
        end
    end

    assign busy           = (state != ST_IDLE);
    assign bus_req        = in_xfer;
    assign src_rd         = (state == ST_RD) && bus_ack;
    assign src_addr       = base_q + SRC_AW'(idx);
    assign spriteram_wr   = (state == ST_WR) && bus_ack;
    assign spriteram_addr = idx;

endmodule
